tracer_chain_driver: RTL and testbench
======================================

TRACER_CHAIN_DRIVER -- requirements
Module: tracer_chain_driver

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 240, number of frame rows (at most 256).
REQ-002 SHALL have parameter NUM_COLS, default 320, number of frame columns (at most 512).
REQ-003 SHALL have parameter NUM_ELEM, default 8, number of tracer elements in the chain.
REQ-004 SHALL have parameter CONTOUR_WORDS, default 2, number of 32-bit contour words per load.
REQ-005 SHALL have parameter DRAIN_CYC, default 16, number of cycles waited after the last pixel.
REQ-006 Ports:
- s_axi_aclk  in  1  clock.
- s_axi_areset  in  1  synchronous active-high reset.
- start  in  1  one-cycle command.
- busy  out  1  high from start accepted until DONE.
- done  out  1  one-cycle pulse at end.
- ctr_valid  in  1  contour word valid.
- ctr_ready  out  1  contour word accept.
- ctr_word  in  32  contour bits, sent LSB first.
- pix_valid  in  1  pixel valid.
- pix_ready  out  1  pixel accept.
- pix_data  in  8  pixel value.
- load_contour  out  1  chain contour shift enable.
- contour_rden  out  1  chain contour read enable.
- contour_data  out  1  serial contour bit.
- load_center  out  1  chain center latch.
- enh_ds_ena  out  1  pixel stream enable.
- enh_ds_row  out  8  pixel stream row.
- enh_ds_col  out  9  pixel stream column.
- enh_ds_data  out  8  pixel stream data.
- store_trace  out  1  chain trace shift.
- ps_acc_trace  out  16  chain head input.
- acc_trace  in  16  chain tail output.
- trace_valid  out  1  readout word valid.
- trace_ready  in  1  readout accept.
- trace_data  out  16  readout word.

Function
REQ-007 SHALL implement states IDLE, CONTOUR, CENTER, SCAN, DRAIN, READOUT, DONE.
REQ-008 IDLE: start moves to CONTOUR and sets busy; start in any other state SHALL be ignored.
REQ-009 CONTOUR: ctr_ready SHALL be high only when the serializer is empty; a word is accepted on ctr_valid&&ctr_ready.
REQ-010 CONTOUR: each accepted word SHALL emit 32 consecutive cycles with load_contour=1, contour_rden=1, contour_data=bit k (k=0..31).
REQ-011 CONTOUR: after CONTOUR_WORDS words are fully shifted, the block SHALL move to CENTER; a gap in ctr_valid SHALL hold load_contour=0.
REQ-012 CENTER: load_center SHALL be 1 for exactly one cycle, then the block moves to SCAN.
REQ-013 SCAN: pix_ready SHALL be 1. Each handshake SHALL register enh_ds_ena=1 and enh_ds_data=pix_data with the current row/col, with 1-cycle latency; cycles without a handshake SHALL give enh_ds_ena=0.
REQ-014 SCAN: col SHALL increment per pixel; at NUM_COLS-1, col wraps to 0 and row increments.
REQ-015 SCAN: the pixel at (NUM_ROWS-1, NUM_COLS-1) SHALL move the block to DRAIN; row/col return to 0.
REQ-016 DRAIN: the block SHALL wait exactly DRAIN_CYC cycles with all chain strobes low, then move to READOUT.
REQ-017 READOUT: trace_valid=1 and trace_data=acc_trace (combinational from chain tail). store_trace=trace_valid&&trace_ready.
REQ-018 READOUT: after NUM_ELEM handshakes the block SHALL move to DONE.
REQ-019 ps_acc_trace SHALL be constant 0.
REQ-020 DONE: done=1 for one cycle, busy cleared, return to IDLE.
REQ-021 pix_ready, ctr_ready and trace_valid SHALL be 0 outside their own states; inputs offered there SHALL be ignored.

Reset
REQ-022 s_axi_areset SHALL force IDLE, clear counters and the serializer, and drive every output to 0.
REQ-023 Reset mid-operation SHALL take effect on the next edge; partial contour, scan or readout progress SHALL be discarded.

Structure
REQ-024 The state encoding and ROW_W=8, COL_W=9, PIX_W=8, TRACE_W=16 SHALL live in shared package tracer_pkg.
REQ-025 The 32-bit parallel-to-serial logic SHALL be sub-module tracer_contour_ser (word load, bit count, empty flag).

Verification
REQ-026 Contour: start, words 0x0000_0001 and 0x8000_0000 -> 64 load_contour cycles, contour_data=1 at bit 0 and bit 63 only, then one load_center pulse.
REQ-027 Scan with NUM_ROWS=2, NUM_COLS=3, pixels 1..6, ctr/pix always valid -> enh_ds row/col (0,0)(0,1)(0,2)(1,0)(1,1)(1,2) with data 1..6, each 1 cycle after its handshake.
REQ-028 Throttle: pix_valid toggled every cycle -> enh_ds_ena pattern matches handshakes; no row/col skips.
REQ-029 Readout: chain model returns 0x0010..0x0017; trace_ready low 3 cycles mid-burst -> store_trace held low for those 3 cycles; 8 words in order; done after the 8th.
REQ-030 Start re-pulsed during SCAN is ignored; reset asserted in READOUT -> next cycle IDLE, all outputs 0, busy=0.
REQ-031 Wrap: NUM_COLS=320, NUM_ROWS=240 -> last pixel at row 239, col 319 enters DRAIN; DRAIN lasts exactly 16 cycles.

Source files
------------

// File: rtl/tracer_pkg.sv
// Shared definitions for the tracer chain driver.
// Holds the state encoding, the datapath widths used on the pixel and
// trace paths, and the registered pixel-stream beat struct.
package tracer_pkg;

    localparam int ROW_W   = 8;
    localparam int COL_W   = 9;
    localparam int PIX_W   = 8;
    localparam int TRACE_W = 16;
    localparam int CTR_W   = 32;

    // Kept as plain logic constants so older tools and the existing
    // waveform decoders still read the raw encoding.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CONTOUR = 3'd1;
    localparam logic [2:0] ST_CENTER  = 3'd2;
    localparam logic [2:0] ST_SCAN    = 3'd3;
    localparam logic [2:0] ST_DRAIN   = 3'd4;
    localparam logic [2:0] ST_READOUT = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic [PIX_W-1:0] data;
    } pix_beat_t;

endpackage

// File: rtl/tracer_chain_driver_if.sv
// Streaming handshakes of the tracer chain driver.
//   ctr_*   : contour words in (valid/ready)
//   pix_*   : pixels in (valid/ready)
//   trace_* : readout words out (valid/ready)
// master = producer of contour/pixel streams and consumer of readout,
// slave  = the driver block.
interface tracer_chain_driver_if;
    import tracer_pkg::*;

    logic               ctr_valid;
    logic               ctr_ready;
    logic [CTR_W-1:0]   ctr_word;
    logic               pix_valid;
    logic               pix_ready;
    logic [PIX_W-1:0]   pix_data;
    logic               trace_valid;
    logic               trace_ready;
    logic [TRACE_W-1:0] trace_data;

    modport master (
        output ctr_valid, ctr_word, pix_valid, pix_data, trace_ready,
        input  ctr_ready, pix_ready, trace_valid, trace_data
    );

    modport slave (
        input  ctr_valid, ctr_word, pix_valid, pix_data, trace_ready,
        output ctr_ready, pix_ready, trace_valid, trace_data
    );

endinterface

// File: rtl/tracer_contour_ser.sv
// 32-bit parallel-to-serial shifter for contour words, LSB first.
//   clk, rst : clock, synchronous active-high reset
//   load     : capture word (only issued while empty)
//   word     : contour word
//   empty    : no bits left, a new word may be loaded
//   bit_vld  : a contour bit is presented this cycle
//   bit_out  : current contour bit (0 when bit_vld is low)
module tracer_contour_ser
    import tracer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CTR_W-1:0] word,
    output logic             empty,
    output logic             bit_vld,
    output logic             bit_out
);

    logic [CTR_W-1:0] sh;
    logic [5:0]       cnt;   // bits still to present

    always_ff @(posedge clk) begin
        if (rst) begin
            sh  <= '0;
            cnt <= '0;
        end else if (load) begin
            sh  <= word;
            cnt <= 6'(CTR_W);
        end else if (cnt != 6'd0) begin
            sh  <= sh >> 1;
            cnt <= cnt - 6'd1;
        end
    end

    assign empty   = (cnt == 6'd0);
    assign bit_vld = !empty;
    assign bit_out = bit_vld & sh[0];

endmodule

// File: rtl/tracer_chain_driver.sv
// Sequencer for a chain of tracer elements: loads contour words serially,
// latches the center, streams one frame of pixels with row/col tags,
// waits for the chain to drain, then reads NUM_ELEM trace words out of
// the chain tail.
//   s_axi_aclk, s_axi_areset : clock, synchronous active-high reset
//   start / busy / done      : command, activity flag, end pulse
//   bus                      : contour, pixel and readout handshakes
//   load_contour, contour_rden, contour_data, load_center : chain load side
//   enh_ds_*                 : registered pixel stream to the chain
//   store_trace, ps_acc_trace, acc_trace : chain readout side
module tracer_chain_driver
    import tracer_pkg::*;
#(
    parameter int NUM_ROWS      = 240,
    parameter int NUM_COLS      = 320,
    parameter int NUM_ELEM      = 8,
    parameter int CONTOUR_WORDS = 2,
    parameter int DRAIN_CYC     = 16
) (
    input  logic                 s_axi_aclk,
    input  logic                 s_axi_areset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    tracer_chain_driver_if.slave bus,
    output logic                 load_contour,
    output logic                 contour_rden,
    output logic                 contour_data,
    output logic                 load_center,
    output logic                 enh_ds_ena,
    output logic [ROW_W-1:0]     enh_ds_row,
    output logic [COL_W-1:0]     enh_ds_col,
    output logic [PIX_W-1:0]     enh_ds_data,
    output logic                 store_trace,
    output logic [TRACE_W-1:0]   ps_acc_trace,
    input  logic [TRACE_W-1:0]   acc_trace
);

    localparam int WCNT_W = $clog2(CONTOUR_WORDS + 1);
    localparam int DCNT_W = $clog2(DRAIN_CYC + 1);
    localparam int RCNT_W = $clog2(NUM_ELEM + 1);

    logic [2:0]        state;
    logic [WCNT_W-1:0] wcnt;
    logic [DCNT_W-1:0] dcnt;
    logic [RCNT_W-1:0] rcnt;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    pix_beat_t         beat_q;

    logic ser_empty, ser_vld, ser_bit;
    logic ctr_hs, pix_hs, trace_hs;

    // Ready only once the previous word has fully left the shifter, so a
    // word is never overwritten mid-shift.
    assign bus.ctr_ready   = (state == ST_CONTOUR) && ser_empty &&
                             (wcnt < WCNT_W'(CONTOUR_WORDS));
    assign bus.pix_ready   = (state == ST_SCAN);
    assign bus.trace_valid = (state == ST_READOUT);
    assign bus.trace_data  = bus.trace_valid ? acc_trace : '0;

    assign ctr_hs   = bus.ctr_valid & bus.ctr_ready;
    assign pix_hs   = bus.pix_valid & bus.pix_ready;
    assign trace_hs = bus.trace_valid & bus.trace_ready;

    tracer_contour_ser u_ser (
        .clk     (s_axi_aclk),
        .rst     (s_axi_areset),
        .load    (ctr_hs),
        .word    (bus.ctr_word),
        .empty   (ser_empty),
        .bit_vld (ser_vld),
        .bit_out (ser_bit)
    );

    assign load_contour = ser_vld;
    assign contour_rden = ser_vld;
    assign contour_data = ser_bit;
    assign load_center  = (state == ST_CENTER);
    assign store_trace  = trace_hs;
    assign ps_acc_trace = '0;
    assign busy         = (state != ST_IDLE) && (state != ST_DONE);
    assign done         = (state == ST_DONE);

    assign enh_ds_row  = beat_q.row;
    assign enh_ds_col  = beat_q.col;
    assign enh_ds_data = beat_q.data;

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            state      <= ST_IDLE;
            wcnt       <= '0;
            dcnt       <= '0;
            rcnt       <= '0;
            row        <= '0;
            col        <= '0;
            beat_q     <= '0;
            enh_ds_ena <= 1'b0;
        end else begin
            enh_ds_ena <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_CONTOUR;
                        wcnt  <= '0;
                        row   <= '0;
                        col   <= '0;
                        rcnt  <= '0;
                    end
                end
                ST_CONTOUR: begin
                    if (ctr_hs)
                        wcnt <= wcnt + 1'b1;
                    // Leave only after the last word's 32 bits are out.
                    if (ser_empty && (wcnt == WCNT_W'(CONTOUR_WORDS)))
                        state <= ST_CENTER;
                end
                ST_CENTER: state <= ST_SCAN;
                ST_SCAN: begin
                    if (pix_hs) begin
                        enh_ds_ena  <= 1'b1;
                        beat_q.row  <= row;
                        beat_q.col  <= col;
                        beat_q.data <= bus.pix_data;
                        if (col == COL_W'(NUM_COLS - 1)) begin
                            col <= '0;
                            if (row == ROW_W'(NUM_ROWS - 1)) begin
                                row   <= '0;
                                dcnt  <= '0;
                                state <= ST_DRAIN;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (dcnt == DCNT_W'(DRAIN_CYC - 1))
                        state <= ST_READOUT;
                    else
                        dcnt <= dcnt + 1'b1;
                end
                ST_READOUT: begin
                    if (trace_hs) begin
                        if (rcnt == RCNT_W'(NUM_ELEM - 1)) begin
                            rcnt  <= '0;
                            state <= ST_DONE;
                        end else begin
                            rcnt <= rcnt + 1'b1;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tracer_chain_driver.sv
// Randomized scoreboard bench for tracer_chain_driver. Stimulus processes
// drive the three input streams; a negedge monitor pushes expectations
// from observed handshakes using a frame-level model (pixel index ->
// row/col, contour word -> 32 bits LSB first, chain returning 0x10+k) and
// pops/compares whenever the DUT presents an output.
module tb_tracer_chain_driver;
    import tracer_pkg::*;

    localparam int NR = 3, NC = 5, NE = 8, CW = 2, DC = 16;
    localparam int BOUND = 4000;

    logic clk = 1'b0;
    logic rst, start;
    logic busy, done, load_contour, contour_rden, contour_data, load_center;
    logic enh_ds_ena, store_trace;
    logic [ROW_W-1:0]   enh_ds_row;
    logic [COL_W-1:0]   enh_ds_col;
    logic [PIX_W-1:0]   enh_ds_data;
    logic [TRACE_W-1:0] ps_acc_trace, acc_trace;

    tracer_chain_driver_if bus ();

    tracer_chain_driver #(
        .NUM_ROWS(NR), .NUM_COLS(NC), .NUM_ELEM(NE),
        .CONTOUR_WORDS(CW), .DRAIN_CYC(DC)
    ) dut (
        .s_axi_aclk(clk), .s_axi_areset(rst), .start(start),
        .busy(busy), .done(done), .bus(bus.slave),
        .load_contour(load_contour), .contour_rden(contour_rden),
        .contour_data(contour_data), .load_center(load_center),
        .enh_ds_ena(enh_ds_ena), .enh_ds_row(enh_ds_row),
        .enh_ds_col(enh_ds_col), .enh_ds_data(enh_ds_data),
        .store_trace(store_trace), .ps_acc_trace(ps_acc_trace),
        .acc_trace(acc_trace)
    );

    always #5 clk = ~clk;

    typedef struct {int row; int col; int data; int cyc;} pexp_t;

    bit    q_ctr[$];
    pexp_t q_pix[$];
    int    q_tr[$];

    int cyc = 0;
    int n_chk = 0, n_pass = 0, n_fail = 0;
    int n_pix = 0, ctr_hs = 0, tr_hs = 0, center_cnt = 0, done_cnt = 0;
    int stall_cyc = 0, last_pix_cyc = 0, last_tr_cyc = 0, first_tv_cyc = -1;
    int start_cyc = 0, tr_idx = 0;
    bit in_frame = 0, rst_seen = 0, to_seen = 0;

    bit ctr_fixed = 1;
    int pix_mode = 0, tr_mode = 0;
    bit timeout_flag = 0;

    // Chain model: tail presents element k's accumulated value 0x10+k.
    assign acc_trace = 16'h0010 + 16'(tr_idx);

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        pexp_t p;
        if (rst) begin
            if (rst_seen) begin
                chk("rst_ctrl", {busy, done, load_contour, contour_rden, contour_data,
                                 load_center, enh_ds_ena, store_trace}, 0);
                chk("rst_ready", {bus.ctr_ready, bus.pix_ready, bus.trace_valid}, 0);
                chk("rst_enh", {enh_ds_row, enh_ds_col, enh_ds_data}, 0);
                chk("rst_trace", {bus.trace_data, ps_acc_trace}, 0);
            end
            rst_seen = 1;
            q_ctr.delete(); q_pix.delete(); q_tr.delete();
            in_frame = 0; tr_idx = 0;
        end else begin
            rst_seen = 0;
            if (start && !in_frame) begin
                in_frame = 1; start_cyc = cyc;
                n_pix = 0; ctr_hs = 0; tr_hs = 0; center_cnt = 0; stall_cyc = 0;
                first_tv_cyc = -1; tr_idx = 0;
                q_ctr.delete(); q_pix.delete(); q_tr.delete();
                for (int k = 0; k < NE; k++) q_tr.push_back(16'h0010 + k);
            end
            if (in_frame && !done && cyc > start_cyc) chk("busy", busy, 1);

            // contour
            if (bus.ctr_ready) chk("ctr_ready_phase", {in_frame, center_cnt == 0}, 2'b11);
            if (bus.ctr_valid && bus.ctr_ready) begin
                for (int b = 0; b < 32; b++) q_ctr.push_back(bus.ctr_word[b]);
                ctr_hs++;
            end
            if (load_contour) begin
                if (q_ctr.size() == 0) chk("contour_extra", 1, 0);
                else chk("contour_data", contour_data, q_ctr.pop_front());
                chk("contour_rden", contour_rden, 1);
            end else if (contour_rden || contour_data)
                chk("contour_idle", {contour_rden, contour_data}, 0);
            if (load_center) begin
                center_cnt++;
                chk("center_after_contour", {q_ctr.size() == 0, ctr_hs == CW}, 2'b11);
            end

            // pixels
            if (bus.pix_ready) chk("pix_ready_phase", {in_frame, center_cnt == 1}, 2'b11);
            if (bus.pix_valid && bus.pix_ready) begin
                p.row = n_pix / NC; p.col = n_pix % NC;
                p.data = int'(bus.pix_data); p.cyc = cyc + 1;
                q_pix.push_back(p);
                n_pix++;
                if (n_pix == NR * NC) last_pix_cyc = cyc;
            end
            if (enh_ds_ena) begin
                if (q_pix.size() == 0) chk("enh_extra", 1, 0);
                else begin
                    p = q_pix.pop_front();
                    chk("enh_row", enh_ds_row, p.row);
                    chk("enh_col", enh_ds_col, p.col);
                    chk("enh_data", enh_ds_data, p.data);
                    chk("enh_latency", cyc, p.cyc);
                end
            end

            // readout
            if (bus.trace_valid) begin
                if (first_tv_cyc < 0) begin
                    first_tv_cyc = cyc;
                    chk("pix_before_readout", n_pix, NR * NC);
                    chk("drain_len", cyc - last_pix_cyc, DC + 1);
                end
                chk("store_trace", store_trace, bus.trace_ready);
                if (!bus.trace_ready) stall_cyc++;
                else begin
                    if (q_tr.size() == 0) chk("trace_extra", 1, 0);
                    else chk("trace_data", bus.trace_data, q_tr.pop_front());
                    tr_hs++;
                    last_tr_cyc = cyc;
                    tr_idx++;
                end
            end else if (store_trace) chk("store_idle", 1, 0);

            if (done) begin
                done_cnt++;
                chk("done_timing", cyc, last_tr_cyc + 1);
                chk("done_busy", busy, 0);
                chk("ctr_words", ctr_hs, CW);
                chk("pix_count", n_pix, NR * NC);
                chk("trace_count", tr_hs, NE);
                chk("center_count", center_cnt, 1);
                if (tr_mode == 0) chk("stall_cycles", stall_cyc, 3);
                in_frame = 0;
            end
        end
        if (timeout_flag && !to_seen) begin
            to_seen = 1;
            chk("timeout", 0, 1);
        end
    end

    // ---------------- stimulus: contour words ----------------
    initial begin
        bit hs;
        bus.ctr_valid = 0; bus.ctr_word = '0;
        forever begin
            @(negedge clk); hs = bus.ctr_valid && bus.ctr_ready;
            @(posedge clk); #1;
            if (hs || !bus.ctr_valid) begin
                bus.ctr_valid = ctr_fixed ? 1'b1 : ($urandom_range(0, 2) != 0);
                bus.ctr_word  = ctr_fixed ? ((ctr_hs == 0) ? 32'h0000_0001 : 32'h8000_0000)
                                          : $urandom;
            end
        end
    end

    // ---------------- stimulus: pixels ----------------
    initial begin
        bit hs;
        bus.pix_valid = 0; bus.pix_data = '0;
        forever begin
            @(negedge clk); hs = bus.pix_valid && bus.pix_ready;
            @(posedge clk); #1;
            if (hs || !bus.pix_valid)
                bus.pix_data = (pix_mode == 0) ? 8'(n_pix + 1) : 8'($urandom);
            case (pix_mode)
                0:       bus.pix_valid = 1'b1;
                1:       bus.pix_valid = !bus.pix_valid;
                default: bus.pix_valid = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- stimulus: readout ready ----------------
    initial begin
        bit stall_done;
        stall_done = 0;
        bus.trace_ready = 1;
        forever begin
            @(posedge clk); #1;
            if (tr_mode == 0) begin
                if (tr_hs == 4 && !stall_done) begin
                    bus.trace_ready = 0;
                    stall_done = 1;
                    repeat (3) @(posedge clk);
                    #1 bus.trace_ready = 1;
                end else bus.trace_ready = 1;
            end else bus.trace_ready = ($urandom_range(0, 2) != 0);
        end
    end

    // ---------------- main sequence ----------------
    task automatic run_frame(input bit fixed, input int pm, input int tm,
                             input bit repulse, input bit abort);
        int d0, i;
        ctr_fixed = fixed; pix_mode = pm; tr_mode = tm; d0 = done_cnt;
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        if (repulse) begin
            i = 0;
            while (i < BOUND && n_pix < 2) begin @(posedge clk); i++; end
            #1 start = 1;
            @(posedge clk); #1 start = 0;
        end
        if (abort) begin
            i = 0;
            while (i < BOUND && tr_hs < 3) begin @(posedge clk); i++; end
            if (tr_hs < 3) timeout_flag = 1;
            #1 rst = 1;
            repeat (2) @(posedge clk);
            #1 rst = 0;
        end else begin
            i = 0;
            while (i < BOUND && done_cnt == d0) begin @(posedge clk); i++; end
            if (done_cnt == d0) timeout_flag = 1;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; start = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        run_frame(1, 0, 0, 0, 0);  // fixed contour words, pixels 1..N, 3-cycle readout stall
        run_frame(0, 1, 1, 1, 0);  // throttled pixels, start re-pulsed mid-scan
        run_frame(0, 2, 1, 0, 1);  // reset in the middle of readout
        run_frame(0, 2, 1, 0, 0);  // clean frame after the abort
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
